// File: rtl/stall_flush_controller.sv
// Pipeline hazard controller: load-use stalls, branch flushes, and a
// mul/div hold FSM, plus a saturating counter of PC-stall cycles.
module stall_flush_controller #(
    parameter int unsigned MD_LATENCY = 4,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             MemReadE,
    input  logic [4:0]       RD_E,
    input  logic [4:0]       Rs1_D,
    input  logic [4:0]       Rs2_D,
    input  logic             PCSrcE,
    input  logic             MdStartE,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             FlushD,
    output logic             FlushE,
    output logic             md_go,
    output logic             md_done,
    output logic             md_busy,
    output logic [CNT_W-1:0] stall_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [7:0] CNT_INIT = 8'(MD_LATENCY - 2);

    state_t             state_q, state_d;
    logic [7:0]         cnt_q, cnt_d;
    logic [CNT_W-1:0]   stall_count_q, stall_count_d;
    logic               lw;
    logic               md_start;

    assign lw = MemReadE && (RD_E != 5'd0) && ((RD_E == Rs1_D) || (RD_E == Rs2_D));
    assign md_start = (state_q == IDLE) && MdStartE;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            stall_count_q <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            stall_count_q <= stall_count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (MdStartE) begin
                    state_d = BUSY;
                    cnt_d   = CNT_INIT;
                end
            end
            BUSY: begin
                if (cnt_q != 8'd0) begin
                    cnt_d = cnt_q - 8'd1;
                end else begin
                    state_d = DONE;
                end
            end
            DONE: begin
                // MdStartE here still belongs to the finishing op, so no restart
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // The md hold takes priority so the op sitting in E is never flushed
    always_comb begin
        StallF  = 1'b0;
        StallD  = 1'b0;
        StallE  = 1'b0;
        FlushD  = 1'b0;
        FlushE  = 1'b0;
        md_go   = 1'b0;
        md_done = 1'b0;
        md_busy = 1'b0;
        if (!rst) begin
            if (md_start || (state_q == BUSY)) begin
                StallF  = 1'b1;
                StallD  = 1'b1;
                StallE  = 1'b1;
                md_go   = md_start;
                md_busy = (state_q == BUSY);
            end else begin
                StallF  = lw;
                StallD  = lw;
                FlushE  = lw || PCSrcE;
                FlushD  = PCSrcE;
                md_done = (state_q == DONE);
            end
        end
    end

    always_comb begin
        stall_count_d = stall_count_q;
        if (StallF && (stall_count_q != '1)) begin
            stall_count_d = stall_count_q + 1'b1;
        end
    end

    assign stall_count = rst ? '0 : stall_count_q;

endmodule

// File: tb/tb_stall_flush_controller.sv
// Directed-vector bench: stimulus pushes expected controls into a
// scoreboard queue; a negedge monitor pops and compares each cycle.
module tb_stall_flush_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic       MemReadE;
    logic [4:0] RD_E;
    logic [4:0] Rs1_D;
    logic [4:0] Rs2_D;
    logic       PCSrcE;
    logic       MdStartE;
    logic       StallF, StallD, StallE, FlushD, FlushE;
    logic       md_go, md_done, md_busy;
    logic [3:0] stall_count;

    always #5 clk = ~clk;

    stall_flush_controller #(
        .MD_LATENCY(4),
        .CNT_W     (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .MemReadE   (MemReadE),
        .RD_E       (RD_E),
        .Rs1_D      (Rs1_D),
        .Rs2_D      (Rs2_D),
        .PCSrcE     (PCSrcE),
        .MdStartE   (MdStartE),
        .StallF     (StallF),
        .StallD     (StallD),
        .StallE     (StallE),
        .FlushD     (FlushD),
        .FlushE     (FlushE),
        .md_go      (md_go),
        .md_done    (md_done),
        .md_busy    (md_busy),
        .stall_count(stall_count)
    );

    // ctl bit order: {StallF, StallD, StallE, FlushD, FlushE, md_go, md_done, md_busy}
    typedef struct {
        string      name;
        logic [7:0] ctl;
        logic [3:0] cnt;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    task automatic step(input string nm, input logic r, input logic mr,
                        input logic [4:0] rd, input logic [4:0] r1, input logic [4:0] r2,
                        input logic pc, input logic ms,
                        input logic [7:0] ctl, input logic [3:0] cnt);
        exp_t e;
        @(posedge clk);
        #1;
        rst      = r;
        MemReadE = mr;
        RD_E     = rd;
        Rs1_D    = r1;
        Rs2_D    = r2;
        PCSrcE   = pc;
        MdStartE = ms;
        e.name = nm;
        e.ctl  = ctl;
        e.cnt  = cnt;
        sb.push_back(e);
    endtask

    initial begin : monitor
        exp_t       e;
        logic [7:0] act;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e   = sb.pop_front();
                act = {StallF, StallD, StallE, FlushD, FlushE, md_go, md_done, md_busy};
                total++;
                if (act !== e.ctl) begin
                    bad++;
                    $display("FAIL %s ctl: got %b expected %b", e.name, act, e.ctl);
                end
                total++;
                if (stall_count !== e.cnt) begin
                    bad++;
                    $display("FAIL %s stall_count: got %0d expected %0d", e.name, stall_count, e.cnt);
                end
            end
        end
    end

    initial begin : stim
        rst = 1'b1; MemReadE = 1'b0; RD_E = '0; Rs1_D = '0; Rs2_D = '0;
        PCSrcE = 1'b0; MdStartE = 1'b0;

        // reset held with hazards present: everything gated to 0
        step("rst0",    1, 1, 5'd5, 5'd5, 5'd0, 1, 1, 8'b0000_0000, 4'd0);
        step("rst1",    1, 1, 5'd5, 5'd5, 5'd0, 1, 0, 8'b0000_0000, 4'd0);

        step("lw_rs1",  0, 1, 5'd5, 5'd5, 5'd0, 0, 0, 8'b1100_1000, 4'd0);
        step("lw_x0",   0, 1, 5'd0, 5'd0, 5'd0, 0, 0, 8'b0000_0000, 4'd1);
        step("lw_rs2",  0, 1, 5'd7, 5'd3, 5'd7, 0, 0, 8'b1100_1000, 4'd1);
        step("noload",  0, 0, 5'd7, 5'd7, 5'd7, 0, 0, 8'b0000_0000, 4'd2);
        step("branch",  0, 0, 5'd0, 5'd0, 5'd0, 1, 0, 8'b0001_1000, 4'd2);
        step("lw_br",   0, 1, 5'd9, 5'd1, 5'd9, 1, 0, 8'b1101_1000, 4'd2);
        step("quiet",   0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 8'b0000_0000, 4'd3);

        step("rst2",    1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 8'b0000_0000, 4'd0);

        // multi-cycle op with hazards injected mid-BUSY
        step("md_t0",   0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 8'b1110_0100, 4'd0);
        step("md_t1",   0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 8'b1110_0001, 4'd1);
        step("md_t2hz", 0, 1, 5'd5, 5'd5, 5'd0, 1, 1, 8'b1110_0001, 4'd2);
        step("md_t3",   0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 8'b1110_0001, 4'd3);
        step("md_t4",   0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 8'b0000_0010, 4'd4);
        step("md_t5",   0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 8'b0000_0000, 4'd4);

        // second op: hazards in DONE are honoured, then immediate restart
        step("md2_s0",  0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 8'b1110_0100, 4'd4);
        step("md2_s1",  0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 8'b1110_0001, 4'd5);
        step("md2_s2",  0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 8'b1110_0001, 4'd6);
        step("md2_s3",  0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 8'b1110_0001, 4'd7);
        step("md2_done",0, 1, 5'd4, 5'd4, 5'd0, 1, 1, 8'b1101_1010, 4'd8);
        step("md3_u0",  0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 8'b1110_0100, 4'd9);
        step("md3_u1",  0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 8'b1110_0001, 4'd10);
        step("md3_rst", 1, 0, 5'd0, 5'd0, 5'd0, 0, 1, 8'b0000_0000, 4'd0);
        step("md3_u3",  0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 8'b0000_0000, 4'd0);
        step("md3_u4",  0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 8'b0000_0000, 4'd0);
        step("md3_u5",  0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 8'b0000_0000, 4'd0);
        step("md3_u6",  0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 8'b0000_0000, 4'd0);

        // 20 load-use cycles saturate the 4-bit counter at 15
        for (int k = 0; k < 20; k++) begin
            step($sformatf("sat%0d", k), 0, 1, 5'd9, 5'd9, 5'd0, 0, 0, 8'b1100_1000,
                 (k > 15) ? 4'd15 : k[3:0]);
        end
        step("sat_hold", 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 8'b0000_0000, 4'd15);

        for (int w = 0; w < 5 && sb.size() > 0; w++) begin
            @(posedge clk);
        end
        @(posedge clk);
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
